// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared widths, FSM states and line alignment for the cache-line adaptor
package cla_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } cla_state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_001f;
  endfunction

endpackage

// File: rtl/cla_write_buffer.sv
// rtl/cla_write_buffer.sv - one-entry line write buffer with line-address hit compare
// Used only when CLA_WRITE_BUFFER_EN is defined.
import cla_pkg::*;

module cla_write_buffer (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LINE_W-1:0] load_line,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] line,
  output logic              hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      line  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= line_addr(load_addr);
      line  <= load_line;
    end
  end

  assign hit = valid && (addr == line_addr(lookup_addr));

endmodule

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts L2 line reads/writes into 4-beat 64-bit memory bursts
// Optional one-entry write buffer enabled by CLA_WRITE_BUFFER_EN.
import cla_pkg::*;

module cacheline_adaptor (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i,
  output logic [ADDR_W-1:0] address_o,
  output logic [BEAT_W-1:0] burst_o,
  output logic              read_o,
  output logic              write_o
);

  cla_state_t        state;
  logic [1:0]        cnt;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] wr_line;
  logic              last_beat;

  assign last_beat = resp_i && (cnt == 2'(BEATS - 1));

`ifdef CLA_WRITE_BUFFER_EN
  logic              buf_valid;
  logic              buf_hit;
  logic              buf_load;
  logic              buf_clear;
  logic [ADDR_W-1:0] buf_addr;
  logic [LINE_W-1:0] buf_line;

  assign buf_load  = (state == ST_IDLE) && write_i && !read_i && !buf_valid;
  assign buf_clear = (state == ST_WR) && last_beat;

  cla_write_buffer u_write_buffer (
    .clk        (clk),
    .rst        (reset_n),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_addr  (address_i),
    .load_line  (line_i),
    .lookup_addr(address_i),
    .valid      (buf_valid),
    .addr       (buf_addr),
    .line       (buf_line),
    .hit        (buf_hit)
  );

  // Writes always burst out of the buffer, so the drain reads it directly.
  assign wr_line = buf_line;
`else
  assign wr_line = line_q;
`endif

  assign burst_o = write_o ? wr_line[BEAT_W*cnt +: BEAT_W] : '0;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      line_q    <= '0;
      line_o    <= '0;
      resp_o    <= 1'b0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef CLA_WRITE_BUFFER_EN
          // Buffer hits bypass memory; any other traffic waits for the drain.
          if (read_i && buf_hit) begin
            line_o <= buf_line;
            resp_o <= 1'b1;
            state  <= ST_DONE;
          end else if (buf_valid) begin
            address_o <= buf_addr;
            write_o   <= 1'b1;
            cnt       <= '0;
            state     <= ST_WR;
          end else if (read_i) begin
            address_o <= line_addr(address_i);
            read_o    <= 1'b1;
            cnt       <= '0;
            state     <= ST_RD;
          end else if (write_i) begin
            resp_o <= 1'b1;
            state  <= ST_DONE;
          end
`else
          if (read_i) begin
            address_o <= line_addr(address_i);
            read_o    <= 1'b1;
            cnt       <= '0;
            state     <= ST_RD;
          end else if (write_i) begin
            address_o <= line_addr(address_i);
            line_q    <= line_i;
            write_o   <= 1'b1;
            cnt       <= '0;
            state     <= ST_WR;
          end
`endif
        end
        ST_RD: begin
          if (resp_i) begin
            line_q[BEAT_W*cnt +: BEAT_W] <= burst_i;
            cnt <= cnt + 2'd1;
            if (last_beat) begin
              line_o <= {burst_i, line_q[LINE_W-BEAT_W-1:0]};
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_WR: begin
          if (resp_i) begin
            cnt <= cnt + 2'd1;
            if (last_beat) begin
              write_o <= 1'b0;
`ifdef CLA_WRITE_BUFFER_EN
              state   <= ST_IDLE;
`else
              resp_o  <= 1'b1;
              state   <= ST_DONE;
`endif
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - randomized self-checking bench with a line-level memory model
// Buffer scenarios run only when CLA_WRITE_BUFFER_EN is defined.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [31:0]  address_i = '0;
  logic [255:0] line_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic         resp_i = 1'b0;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;
  logic         read_o;
  logic         write_o;

  cacheline_adaptor dut (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .line_i(line_i),
    .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .resp_i(resp_i), .address_o(address_o), .burst_o(burst_o),
    .read_o(read_o), .write_o(write_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // mem: what the DUT bursts actually put in memory; ref_mem: what L2 asked for
  logic [255:0] mem [logic [26:0]];
  logic [255:0] ref_mem [logic [26:0]];

  int gap_lo = 0, gap_hi = 0, gap = 0, beat = 0;
  logic [255:0] wline = '0;
  int cyc = 0, rd_cyc = 0, wr_cyc = 0, resp_cnt = 0, last_wbeat_cyc = 0, first_rd_cyc = -1;

  function automatic logic [255:0] fill(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:5], 5'b0};
    return {4{la ^ 32'h5a5a_0000, ~la}};
  endfunction

  function automatic logic [255:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:5])) return mem[a[31:5]];
    return fill(a);
  endfunction

  function automatic logic [255:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:5])) return ref_mem[a[31:5]];
    return fill(a);
  endfunction

  // memory responder: one beat per strobe, randomized gaps
  initial forever begin
    logic [255:0] tmp;
    @(posedge clk); #1;
    resp_i = 1'b0;
    if (reset_n) begin
      beat = 0;
      gap = 0;
    end else if (read_o || write_o) begin
      if (gap > 0) gap--;
      else begin
        resp_i = 1'b1;
        if (read_o) begin
          tmp = mem_rd(address_o);
          burst_i = tmp[64*beat +: 64];
        end else begin
          wline[64*beat +: 64] = burst_o;
        end
        beat++;
        if (beat == 4) begin
          if (write_o) begin
            mem[address_o[31:5]] = wline;
            last_wbeat_cyc = cyc;
          end
          beat = 0;
        end
        gap = $urandom_range(gap_hi, gap_lo);
      end
    end
  end

  // monitor: cycle accounting and burst-hold check, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (read_o) begin
      rd_cyc++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (write_o) wr_cyc++;
    if (resp_o) resp_cnt++;
    if (beat != 0 && !reset_n) begin
      total++;
      if (!(read_o || write_o)) begin
        bad++;
        $display("FAIL burst_hold: read_o=%0b write_o=%0b at beat %0d, required request held", read_o, write_o, beat);
      end
    end
  end

  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] d,
                      output logic [255:0] got, output int lat);
    logic ok;
    read_i = rd; write_i = wr; address_i = a; line_i = d;
    if (wr && !rd) ref_mem[a[31:5]] = d;
    lat = 0; ok = 1'b0; got = '0;
    repeat (400) begin
      @(posedge clk); #1;
      lat++;
      if (resp_o) begin
        ok = 1'b1;
        got = line_o;
        break;
      end
    end
    read_i = 1'b0; write_i = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL xact_timeout: no resp_o for addr %h, required within 400 cycles", a);
    end else begin
      @(posedge clk); #1;
      total++;
      if (resp_o !== 1'b0) begin
        bad++;
        $display("FAIL resp_pulse: resp_o=%b one cycle later, required 0", resp_o);
      end
    end
  endtask

  task automatic wait_drained();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 300) begin
      @(posedge clk); #1;
      n++;
      quiet = (read_o || write_o) ? 0 : quiet + 1;
    end
    total++;
    if (quiet < 3) begin
      bad++;
      $display("FAIL drain_timeout: memory port still busy, required idle");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: rd/wr/resp=%b, required 000", {read_o, write_o, resp_o});
    end
    total++;
    if (line_o !== '0 || address_o !== '0 || burst_o !== '0) begin
      bad++;
      $display("FAIL reset_data: line_o=%h address_o=%h burst_o=%h, required all 0", line_o, address_o, burst_o);
    end
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic test_read_basic();
    logic [255:0] got;
    logic [255:0] exp_line;
    int lat, rd0, rs0;
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mem[27'h0000_1234 >> 5] = exp_line;
    ref_mem[27'h0000_1234 >> 5] = exp_line;
    gap_lo = 0; gap_hi = 0; gap = 0;
    rd0 = rd_cyc; rs0 = resp_cnt;
    xact(1'b1, 1'b0, 32'h0000_1234, '0, got, lat);
    total++;
    if (got !== exp_line) begin bad++; $display("FAIL read_line: got %h, required %h", got, exp_line); end
    total++;
    if (address_o !== 32'h0000_1220) begin bad++; $display("FAIL read_addr: got %h, required 00001220", address_o); end
    total++;
    if (lat + 1 !== 6) begin bad++; $display("FAIL read_latency: got %0d cycles, required 6", lat + 1); end
    total++;
    if (rd_cyc - rd0 !== 4) begin bad++; $display("FAIL read_hold: read_o high %0d cycles, required 4", rd_cyc - rd0); end
    total++;
    if (resp_cnt - rs0 !== 1) begin bad++; $display("FAIL read_resp_count: got %0d, required 1", resp_cnt - rs0); end
  endtask

  task automatic test_write_gaps();
    logic [255:0] got;
    logic [255:0] wl;
    int lat, wr0, rs0;
    wl = {64'hAAAA_AAAA_AAAA_AAA3, 64'hAAAA_AAAA_AAAA_AAA2,
          64'hBBBB_BBBB_BBBB_BBB1, 64'hBBBB_BBBB_BBBB_BBB0};
    gap_lo = 2; gap_hi = 2; gap = 0;
    wr0 = wr_cyc; rs0 = resp_cnt;
    xact(1'b0, 1'b1, 32'h8000_0040, wl, got, lat);
    wait_drained();
    total++;
    if (mem_rd(32'h8000_0040) !== wl) begin
      bad++; $display("FAIL write_line: memory holds %h, required %h", mem_rd(32'h8000_0040), wl);
    end
    total++;
    if (address_o !== 32'h8000_0040) begin bad++; $display("FAIL write_addr: got %h, required 80000040", address_o); end
    total++;
    if (wr_cyc - wr0 !== 10) begin bad++; $display("FAIL write_hold: write_o high %0d cycles, required 10", wr_cyc - wr0); end
    total++;
    if (resp_cnt - rs0 !== 1) begin bad++; $display("FAIL write_resp_count: got %0d, required 1", resp_cnt - rs0); end
`ifdef CLA_WRITE_BUFFER_EN
    total++;
    if (lat + 1 !== 2) begin bad++; $display("FAIL write_latency: got %0d cycles, required 2", lat + 1); end
`else
    total++;
    if (lat + 1 !== 12) begin bad++; $display("FAIL write_latency: got %0d cycles, required 12", lat + 1); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] got;
    int lat, n;
    mem[27'h0000_2000 >> 5] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ref_mem[27'h0000_2000 >> 5] = mem[27'h0000_2000 >> 5];
    gap_lo = 1; gap_hi = 1; gap = 0;
    read_i = 1'b1; address_i = 32'h0000_2000;
    n = 0;
    while (beat != 2 && n < 100) begin @(negedge clk); n++; end
    reset_n = 1'b1;
    #1;
    read_i = 1'b0;
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== '0) begin
      bad++;
      $display("FAIL reset_mid: rd/wr/resp=%b address_o=%h, required 000 and 0", {read_o, write_o, resp_o}, address_o);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    gap_lo = 0; gap_hi = 3;
    xact(1'b1, 1'b0, 32'h0000_2000, '0, got, lat);
    total++;
    if (got !== ref_rd(32'h0000_2000)) begin
      bad++; $display("FAIL reset_reread: got %h, required %h", got, ref_rd(32'h0000_2000));
    end
  endtask

  task automatic test_both_requests();
    logic [255:0] got;
    int lat, wr0, rd0;
    wr0 = wr_cyc; rd0 = rd_cyc;
    xact(1'b1, 1'b1, 32'h0000_3010, {8{32'hdead_beef}}, got, lat);
    total++;
    if (wr_cyc - wr0 !== 0) begin bad++; $display("FAIL both_write: write_o high %0d cycles, required 0", wr_cyc - wr0); end
    total++;
    if (rd_cyc - rd0 < 4) begin bad++; $display("FAIL both_read: read_o high %0d cycles, required >=4", rd_cyc - rd0); end
    total++;
    if (got !== ref_rd(32'h0000_3010)) begin bad++; $display("FAIL both_line: got %h, required %h", got, ref_rd(32'h0000_3010)); end
  endtask

  task automatic test_random();
    logic [255:0] got;
    logic [255:0] d;
    logic [31:0] a;
    int lat;
    gap_lo = 0; gap_hi = 3;
    for (int i = 0; i < 24; i++) begin
      a = 32'h0000_0400 + 32'($urandom_range(3, 0)) * 32'h20 + 32'($urandom_range(31, 0));
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(1, 0) == 1) begin
        xact(1'b0, 1'b1, a, d, got, lat);
      end else begin
        xact(1'b1, 1'b0, a, '0, got, lat);
        total++;
        if (got !== ref_rd(a)) begin bad++; $display("FAIL random_read[%0d]: addr %h got %h, required %h", i, a, got, ref_rd(a)); end
      end
    end
    wait_drained();
    for (int i = 0; i < 4; i++) begin
      a = 32'h0000_0400 + 32'(i) * 32'h20;
      total++;
      if (mem_rd(a) !== ref_rd(a)) begin bad++; $display("FAIL random_mem[%0d]: memory %h, required %h", i, mem_rd(a), ref_rd(a)); end
    end
  endtask

`ifdef CLA_WRITE_BUFFER_EN
  task automatic test_buffer_hit();
    logic [255:0] got;
    logic [255:0] wl;
    int lat, rd0;
    wait_drained();
    wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xact(1'b0, 1'b1, 32'h0000_0100, wl, got, lat);
    total++;
    if (lat + 1 !== 2) begin bad++; $display("FAIL buf_write_latency: got %0d cycles, required 2", lat + 1); end
    rd0 = rd_cyc;
    xact(1'b1, 1'b0, 32'h0000_0100, '0, got, lat);
    total++;
    if (got !== wl) begin bad++; $display("FAIL buf_hit_line: got %h, required %h", got, wl); end
    total++;
    if (rd_cyc - rd0 !== 0) begin bad++; $display("FAIL buf_hit_noread: read_o high %0d cycles, required 0", rd_cyc - rd0); end
  endtask

  task automatic test_buffer_drain_order();
    logic [255:0] got;
    int lat;
    wait_drained();
    gap_lo = 0; gap_hi = 2;
    xact(1'b0, 1'b1, 32'h0000_0100, {8{$urandom}}, got, lat);
    first_rd_cyc = -1;
    xact(1'b1, 1'b0, 32'h0000_0200, '0, got, lat);
    total++;
    if (!(first_rd_cyc > last_wbeat_cyc)) begin
      bad++; $display("FAIL buf_drain_order: read_o rose at %0d, last drain beat %0d, required later", first_rd_cyc, last_wbeat_cyc);
    end
    total++;
    if (got !== ref_rd(32'h0000_0200)) begin bad++; $display("FAIL buf_miss_line: got %h, required %h", got, ref_rd(32'h0000_0200)); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_gaps();
    test_reset_mid_burst();
    test_both_requests();
    test_random();
`ifdef CLA_WRITE_BUFFER_EN
    test_buffer_hit();
    test_buffer_drain_order();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts 256-bit cache-line reads and writes from the L2 cache into 4-beat, 64-bit burst transactions on the physical-memory port, and reassembles read bursts into lines. Sits directly below the L2 cache, which itself is fed by the I/D-cache arbiter; it is the last stage before memory. Handles one line transaction at a time. An optional one-entry write buffer lets L2 write-backs retire before the burst drains.

## Interface
Parameters:
- none (widths fixed in `cla_pkg`)

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `reset_n` in 1 — asynchronous, active-high reset (codebase naming; high = reset)
- `address_i` in 32 — L2 line address; bits [4:0] ignored
- `line_i` in 256 — write line from L2
- `read_i` in 1 — L2 line read request, held until `resp_o`
- `write_i` in 1 — L2 line write request, held until `resp_o`
- `line_o` out 256 — assembled read line, valid while `resp_o`=1
- `resp_o` out 1 — one-cycle completion pulse to L2
- `burst_i` in 64 — memory read beat
- `resp_i` in 1 — memory beat strobe: one per beat, gaps allowed
- `address_o` out 32 — `{addr[31:5],5'b0}`, stable for whole burst
- `burst_o` out 64 — current write beat
- `read_o` out 1 — memory burst read request, held until 4th beat
- `write_o` out 1 — memory burst write request, held until 4th beat

## Operation
- States: IDLE, RD (beats 0–3), WR (beats 0–3), DONE.
- Reset values: all outputs 0, `line_o`=0, state IDLE, beat counter 0, write buffer invalid.
- IDLE: `read_i` → latch aligned address, go RD. `write_i` → latch address and `line_i`, go WR. Both high → read wins; protocol violation, not otherwise checked.
- RD: `read_o`=1. Each `resp_i` stores `burst_i` into `line[64*k +: 64]` (k = counter, beat 0 = bits [63:0]) and increments the 2-bit counter. The 4th strobe goes to DONE and deasserts `read_o` next cycle.
- WR: `write_o`=1, `burst_o`=`line[64*k +: 64]`. Each `resp_i` advances k. The 4th strobe goes to DONE.
- DONE: `resp_o`=1 for exactly one cycle, `line_o` = assembled line, then IDLE. The counter wraps 3→0 at burst end.
- `resp_i` outside RD/WR is ignored.
- Reset mid-burst: immediate return to IDLE, `read_o`/`write_o` drop asynchronously, partial line discarded, buffer invalidated.

## Timing
- Read latency: `resp_o` is asserted the cycle after the 4th `resp_i`. Minimum is 6 cycles from `read_i`: 1 capture cycle, 4 beats, 1 DONE.
- Write latency is the same minimum without the buffer.
- The earliest new request is accepted in the cycle after DONE, when IDLE samples it. L2 must drop the request in the cycle after `resp_o`; a still-high request starts a new transaction.
- `address_o` and `burst_o` change only on strobe edges or state entry.

## Configuration
- `CLA_WRITE_BUFFER_EN` defined:
  - `write_i` in IDLE with the buffer empty copies the line and address into the buffer, then pulses `resp_o` the next cycle (2-cycle write).
  - The buffer drains through WR in the background.
  - A read during the drain waits until the drain completes.
  - A read whose line address matches a valid buffer hits: `line_o` is returned from the buffer in DONE with no memory access.
  - A write while the buffer is full stalls until the drain completes.
  - The buffer is invalidated at the 4th drain beat.
- Undefined:
  - No buffer; writes complete only after the burst.
  - `resp_o` is never early.

## Structure
- `cla_pkg`: `LINE_W`=256, `BEAT_W`=64, `BEATS`=4, `cla_state_t` enum, `line_addr()` alignment function.
- One sub-module, `cla_write_buffer`: valid bit, address and line registers, hit compare. Instantiated only under `CLA_WRITE_BUFFER_EN`.
- The top-level holds the FSM, beat counter and assembly register.

## Test plan
- Read 0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. back-to-back → `address_o`=0x0000_1220, `line_o`={0x44..,0x33..,0x22..,0x11..}, `resp_o` one cycle, 6 cycles total.
- Write line 0xAA..AA_BB.. to 0x8000_0040 with 2-cycle gaps between `resp_i` → `burst_o` sequence = line[63:0]..line[255:192], `write_o` held through gaps, single `resp_o`.
- `reset_n` high after beat 2 of a read → outputs 0 same cycle. The next read restarts at beat 0 and returns the correct line.
- `read_i` and `write_i` both high → read burst only, `write_o` never asserted.
- `CLA_WRITE_BUFFER_EN`: write to 0x100, then immediately read 0x100 → write `resp_o` 2 cycles after request; read returns the written line from the buffer with no `read_o` asserted.
- `CLA_WRITE_BUFFER_EN`: write 0x100, then read 0x200 → `read_o` rises only after the 4th write-drain beat.
